// File: rtl/piso_pkg.sv
// Shared types and parameter limits for the piso_stream serialiser.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    function automatic bit width_ok(input int width);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready on both sides; one bit per transfer.
// Integrators: in_ready depends combinationally on out_ready (back-to-back reload path).
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "piso_stream: WIDTH must lie in 2..64");
    end

    piso_state_t      state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic             at_last;

    assign at_last = (bit_cnt == '0);
    assign shifted = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);

    assign out_valid  = (state == SHIFT);
    assign busy       = out_valid;
    assign out_last   = out_valid & at_last;
    assign serial_out = out_valid & (LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1]);

    // A new word may enter while the final bit of the current one is being taken.
    assign in_ready = reset_n & ((state == IDLE) | ((state == SHIFT) & at_last & out_ready));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        bit_cnt   <= CNT_MAX;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (!at_last) begin
                            shift_reg <= shifted;
                            bit_cnt   <= bit_cnt - CNT_W'(1);
                        end else if (in_valid) begin
                            shift_reg <= in_data;
                            bit_cnt   <= CNT_MAX;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: four lanes (8/MSB, 8/LSB, 2/MSB, 33/LSB) checked against a bit-queue model and a word scoreboard.
module tb_piso_stream;

    logic        clk;
    logic        reset_n;
    logic [63:0] in_data [4];
    logic [3:0]  in_valid;
    logic [3:0]  out_ready;
    logic [3:0]  in_ready;
    logic [3:0]  serial_out;
    logic [3:0]  out_valid;
    logic [3:0]  out_last;
    logic [3:0]  busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    event final_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    endtask

    // Each lane owns a DUT, a bit-queue reference model and a word scoreboard.
    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int W   = (g == 2) ? 2 : (g == 3) ? 33 : 8;
        localparam bit LSB = (g == 1) || (g == 3);

        logic [W-1:0] din;
        assign din = in_data[g][W-1:0];

        piso_stream #(.WIDTH(W), .LSB_FIRST(LSB)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_data    (din),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .serial_out (serial_out[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_last   (out_last[g]),
            .busy       (busy[g])
        );

        bit           pend[$];
        logic [W-1:0] exp_words[$];
        bit           got[$];
        int           words_in;
        int           words_out;

        // Model: pend holds the bits of the word in flight, in wire order.
        initial begin
            bit take;
            bit acc;
            forever begin
                @(posedge clk);
                take = (pend.size() > 0) && out_ready[g];
                acc  = reset_n && in_valid[g] &&
                       ((pend.size() == 0) || ((pend.size() == 1) && out_ready[g]));
                if (!reset_n) begin
                    pend.delete();
                end else begin
                    if (take) void'(pend.pop_front());
                    if (acc)
                        for (int i = 0; i < W; i++)
                            pend.push_back(LSB ? din[i] : din[W-1-i]);
                end
            end
        end

        initial begin
            bit e_valid;
            bit e_serial;
            bit e_last;
            bit e_ready;
            forever begin
                @(negedge clk);
                e_valid  = pend.size() > 0;
                e_serial = e_valid ? pend[0] : 1'b0;
                e_last   = pend.size() == 1;
                e_ready  = reset_n && ((pend.size() == 0) || ((pend.size() == 1) && out_ready[g]));
                checkOutput($sformatf("lane%0d out_valid", g), 64'(out_valid[g]), 64'(e_valid));
                checkOutput($sformatf("lane%0d serial_out", g), 64'(serial_out[g]), 64'(e_serial));
                checkOutput($sformatf("lane%0d out_last", g), 64'(out_last[g]), 64'(e_last));
                checkOutput($sformatf("lane%0d in_ready", g), 64'(in_ready[g]), 64'(e_ready));
                checkOutput($sformatf("lane%0d busy", g), 64'(busy[g]), 64'(e_valid));
            end
        end

        // Scoreboard: rebuild words from observed transfers and match accepted words.
        initial begin
            logic [W-1:0] word;
            words_in  = 0;
            words_out = 0;
            forever begin
                @(posedge clk);
                if (!reset_n) begin
                    exp_words.delete();
                    got.delete();
                    words_in  = 0;
                    words_out = 0;
                end else begin
                    if (in_valid[g] && in_ready[g]) begin
                        exp_words.push_back(din);
                        words_in++;
                    end
                    if (out_valid[g] && out_ready[g]) begin
                        got.push_back(serial_out[g]);
                        if (out_last[g]) begin
                            word = '0;
                            for (int i = 0; i < got.size(); i++)
                                if (i < W) begin
                                    if (LSB) word[i] = got[i];
                                    else     word[W-1-i] = got[i];
                                end
                            checkOutput($sformatf("lane%0d word length", g), 64'(got.size()), 64'(W));
                            if (exp_words.size() == 0)
                                checkOutput($sformatf("lane%0d unexpected word", g), 64'(word), 64'(~word));
                            else
                                checkOutput($sformatf("lane%0d word", g), 64'(word), 64'(exp_words.pop_front()));
                            words_out++;
                            got.delete();
                        end
                    end
                end
            end
        end

        initial begin
            @(final_ev);
            checkOutput($sformatf("lane%0d last count", g), 64'(words_out), 64'(words_in));
            checkOutput($sformatf("lane%0d words left", g), 64'(exp_words.size()), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int l, input logic valid, input logic [63:0] data, input logic ready);
        in_valid[l]  = valid;
        in_data[l]   = data;
        out_ready[l] = ready;
    endtask

    // Samples lanes 0 and 1 for n cycles, first bit ending up most significant.
    task automatic collectBits(input int n, output logic [63:0] bits0, output logic [63:0] last0,
                               output logic [63:0] bits1, output logic [63:0] last1);
        bits0 = '0; last0 = '0; bits1 = '0; last1 = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bits0 = {bits0[62:0], serial_out[0]};
            last0 = {last0[62:0], out_last[0]};
            bits1 = {bits1[62:0], serial_out[1]};
            last1 = {last1[62:0], out_last[1]};
            tick();
        end
    endtask

    initial begin
        logic [63:0] b0, l0, b1, l1;
        logic [63:0] valids, readys;

        reset_n = 1'b0;
        for (int l = 0; l < 4; l++) applyStimulus(l, 1'b0, 64'd0, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset in_ready", 64'(in_ready), 64'h0);
        checkOutput("reset out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset serial_out", 64'(serial_out), 64'h0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset in_ready", 64'(in_ready), 64'hF);
        tick();

        $display("[TB] single word 0x2D, both bit orders");
        applyStimulus(0, 1'b1, 64'h2D, 1'b1);
        applyStimulus(1, 1'b1, 64'h2D, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b1);
        applyStimulus(1, 1'b0, 64'h0, 1'b1);
        collectBits(8, b0, l0, b1, l1);
        checkOutput("msb-first bits", b0, 64'h2D);
        checkOutput("msb-first last", l0, 64'h01);
        checkOutput("lsb-first bits", b1, 64'hB4);
        checkOutput("lsb-first last", l1, 64'h01);
        @(negedge clk);
        checkOutput("idle in_ready", 64'(in_ready[0]), 64'h1);
        checkOutput("idle out_valid", 64'(out_valid[0]), 64'h0);
        tick();

        $display("[TB] backpressure on third bit");
        applyStimulus(0, 1'b1, 64'h2D, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b1);
        collectBits(2, b0, l0, b1, l1);
        checkOutput("bp first bits", b0, 64'h0);
        applyStimulus(0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp serial hold", 64'(serial_out[0]), 64'h1);
            checkOutput("bp valid hold", 64'(out_valid[0]), 64'h1);
            checkOutput("bp in_ready", 64'(in_ready[0]), 64'h0);
            checkOutput("bp last hold", 64'(out_last[0]), 64'h0);
            tick();
        end
        applyStimulus(0, 1'b0, 64'h0, 1'b1);
        collectBits(6, b0, l0, b1, l1);
        checkOutput("bp remaining bits", b0, 64'h2D);
        checkOutput("bp remaining last", l0, 64'h01);

        $display("[TB] back-to-back words");
        applyStimulus(0, 1'b1, 64'h2D, 1'b1);
        tick();
        in_data[0] = 64'hF0;
        b0 = '0; valids = '0; readys = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b0     = {b0[62:0], serial_out[0]};
            valids = {valids[62:0], out_valid[0]};
            readys = {readys[62:0], in_ready[0]};
            tick();
            if (i == 7) in_valid[0] = 1'b0;
        end
        checkOutput("b2b bits", b0, 64'h2DF0);
        checkOutput("b2b valid", valids, 64'hFFFF);
        checkOutput("b2b in_ready", readys, 64'h0101);

        $display("[TB] reset mid-word");
        applyStimulus(0, 1'b1, 64'hFF, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b1);
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("mid reset out_valid", 64'(out_valid[0]), 64'h0);
        checkOutput("mid reset serial_out", 64'(serial_out[0]), 64'h0);
        checkOutput("mid reset out_last", 64'(out_last[0]), 64'h0);
        checkOutput("mid reset in_ready", 64'(in_ready[0]), 64'h0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("release in_ready", 64'(in_ready[0]), 64'h1);
        checkOutput("release out_valid", 64'(out_valid[0]), 64'h0);
        tick();
        applyStimulus(0, 1'b1, 64'h81, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b1);
        collectBits(8, b0, l0, b1, l1);
        checkOutput("after reset bits", b0, 64'h81);
        checkOutput("after reset last", l0, 64'h01);

        $display("[TB] random traffic on all lanes");
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < 4; l++)
                applyStimulus(l, $urandom_range(0, 9) < 6, {$urandom(), $urandom()},
                              $urandom_range(0, 9) < 7);
            tick();
        end
        for (int l = 0; l < 4; l++) applyStimulus(l, 1'b0, 64'h0, 1'b1);
        repeat (40) tick();

        -> final_ev;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
